// File: rtl/decoder_two_four_pkg.sv
// Shared constants and types for the registered 2-to-4 one-hot decoder.
package decoder_two_four_pkg;

    localparam int unsigned DEC_IN_W  = 2;
    localparam int unsigned DEC_OUT_W = 4;

    typedef logic [DEC_OUT_W-1:0] dec_onehot_t;

    // True when v is all-zero or has exactly one bit set.
    function automatic logic dec_is_onehot0(input dec_onehot_t v);
        return (v & (v - DEC_OUT_W'(1))) == '0;
    endfunction

endpackage : decoder_two_four_pkg

// File: rtl/decoder_two_four_dec2to4_comb.sv
// Pure combinational binary-to-one-hot decode, gated by enable.
module dec2to4_comb
    import decoder_two_four_pkg::*;
#(
    parameter  int unsigned IN_W  = DEC_IN_W,
    localparam int unsigned OUT_W = 1 << IN_W
) (
    input  logic [IN_W-1:0]  sel,
    input  logic             en,
    output logic [OUT_W-1:0] dec_c
);

    always_comb begin
        dec_c = '0;
        for (int unsigned i = 0; i < OUT_W; i++) begin
            dec_c[i] = en && (sel == IN_W'(i));
        end
    end

endmodule : dec2to4_comb

// File: rtl/decoder_two_four.sv
// Registered 2-to-4 one-hot decoder; output updates one clk after in/en are sampled.
module decoder_two_four
    import decoder_two_four_pkg::*;
#(
    parameter  int unsigned IN_W  = DEC_IN_W,
    localparam int unsigned OUT_W = 1 << IN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in,
    input  logic             en,
    output logic [OUT_W-1:0] o
);

    logic [OUT_W-1:0] dec_c;

    dec2to4_comb #(
        .IN_W (IN_W)
    ) u_dec (
        .sel   (in),
        .en    (en),
        .dec_c (dec_c)
    );

    // Output register is the only state; reset wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            o <= '0;
        end else begin
            o <= dec_c;
        end
    end

endmodule : decoder_two_four

// File: tb/tb_decoder_two_four.sv
// Self-checking bench for decoder_two_four: directed plan plus randomized run vs a table model.
module tb_decoder_two_four;

    logic       clk;
    logic       rst;
    logic [1:0] in;
    logic       en;
    logic [3:0] o;

    int checks   = 0;
    int failures = 0;

    logic [3:0] onehot_tab [4];

    decoder_two_four dut (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .en  (en),
        .o   (o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] model(input logic r, input logic [1:0] s, input logic e);
        if (r || !e) return 4'b0000;
        return onehot_tab[s];
    endfunction

    task automatic check(input string tag, input logic [3:0] exp);
        checks++;
        assert (o === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, o, exp);
        end
        checks++;
        assert (($countones(o) <= 1) === 1'b1) else begin
            failures++;
            $error("FAIL %s_onehot: observed=%b expected=zero_or_onehot", tag, o);
        end
    endtask

    // Drive inputs, take one rising edge, then compare against the model.
    task automatic step(input string tag, input logic r, input logic [1:0] s, input logic e);
        rst = r;
        in  = s;
        en  = e;
        @(posedge clk);
        #1;
        check(tag, model(r, s, e));
    endtask

    initial begin
        logic       r;
        logic [1:0] s;
        logic       e;

        onehot_tab[0] = 4'b0001;
        onehot_tab[1] = 4'b0010;
        onehot_tab[2] = 4'b0100;
        onehot_tab[3] = 4'b1000;

        rst = 1'b1;
        in  = 2'b11;
        en  = 1'b1;
        @(negedge clk);

        // Reset holds output low regardless of in/en.
        step("reset0", 1'b1, 2'b11, 1'b1);
        step("reset1", 1'b1, 2'b11, 1'b1);
        step("post_reset", 1'b0, 2'b11, 1'b1);

        step("sweep01", 1'b0, 2'b01, 1'b1);
        step("sweep00", 1'b0, 2'b00, 1'b1);
        step("sweep10", 1'b0, 2'b10, 1'b1);
        step("sweep11", 1'b0, 2'b11, 1'b1);

        step("gate_off11", 1'b0, 2'b11, 1'b0);
        step("gate_on10",  1'b0, 2'b10, 1'b1);
        step("gate_off01", 1'b0, 2'b01, 1'b0);
        step("gate_on00",  1'b0, 2'b00, 1'b1);

        step("mid_pre",   1'b0, 2'b10, 1'b1);
        step("mid_rst",   1'b1, 2'b01, 1'b1);
        step("mid_after", 1'b0, 2'b01, 1'b1);

        // Inputs wiggle between edges; output must hold until the next rising edge.
        step("hold_base", 1'b0, 2'b10, 1'b1);
        in = 2'b00;
        #2;
        check("hold_in_change", 4'b0100);
        en = 1'b0;
        #2;
        check("hold_en_change", 4'b0100);
        in = 2'b11;
        en = 1'b1;
        #1;
        check("hold_both_change", 4'b0100);
        @(posedge clk);
        #1;
        check("hold_next_edge", 4'b1000);

        for (int n = 0; n < 1000; n++) begin
            r = ($urandom_range(0, 9) == 0);
            s = 2'($urandom_range(0, 3));
            e = ($urandom_range(0, 3) != 0);
            step("random", r, s, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_decoder_two_four

// File: doc/decoder_two_four.md
Name: decoder_two_four

Overview:
Registered 2-to-4 one-hot decoder with active-high enable.
- Each clock it samples a 2-bit select plus enable and drives a 4-bit one-hot output (all-zero when disabled).
- Used as a leaf address/select decoder in single-clock datapaths.
- Output is registered to give a clean, glitch-free select after one cycle.

Parameters:
- IN_W, 2, select width in bits. Only 2 is a required/verified configuration.
- OUT_W, 4, output width; fixed as 2**IN_W. Not independently overridable.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in   input  IN_W (2)  binary select code.
- en   input  1  decode enable, active high.
- o    output OUT_W (4)  registered one-hot decode result.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - rising clk with rst=1 -> o <= 4'b0000, regardless of in/en.
  - rst has priority over en.
  - rst asserted mid-operation clears o on the next edge; no other state exists.
- Decode, on rising clk with rst=0:
  - en=1 -> o <= (1 << in), i.e. o[in]=1 and all other bits 0.
    - in=00 -> 0001
    - in=01 -> 0010
    - in=10 -> 0100
    - in=11 -> 1000
  - en=0 -> o <= 0000 for any value of in.
- Latency: exactly one clk cycle from sampled in/en to o. No combinational path from inputs to o.
- Invariant: o is always either 0000 or exactly one bit set; never multi-hot.
- Back-to-back changes: every cycle is independent. No handshake, no hold, no history.
- Unknown/X on in while en=1: o is don't-care. Verification must not drive X on in when en=1.
- No state machine; the only state is the 4-bit output register.

Decomposition:
- Shared package: DEC_IN_W=2 and DEC_OUT_W=4 constants, plus a one-hot typedef for the 4-bit output.
- Optional sub-module dec2to4_comb: pure combinational decode. The top wraps it with the output register and reset/enable logic.
- A single module is equally acceptable.

Test Plan:
1. Reset: rst=1 for 2 cycles with in=11, en=1 -> o=0000 on each edge; after release with the same inputs, o=1000 one cycle later.
2. Full sweep: en=1, drive in=01, 00, 10, 11 on successive cycles -> o=0010, 0001, 0100, 1000, each appearing one cycle after its input.
3. Enable gating: in=11, en=0 -> o=0000; then in=10, en=1 -> o=0100; then in=01, en=0 -> o=0000; then in=00, en=1 -> o=0001.
4. Reset mid-stream: en=1, in=10 (o=0100), assert rst for one cycle with in=01 -> o=0000. Next cycle with rst=0 -> o=0010.
5. Latency/no-comb-path check: change in/en between clock edges -> o stays stable until the next rising clk.
6. Randomized: random in/en/rst for 1000 cycles -> o matches a reference model one cycle later and is always zero or one-hot.
